// File: rtl/dff_chk_pkg.sv
// Shared types and constants for the D flip-flop response checker.
package dff_chk_pkg;

    localparam int MAX_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    typedef struct packed {
        logic exp;
        logic valid;
    } exp_t;

    // Golden D flip-flop: reset beats set, set beats data.
    function automatic logic dff_model(input logic d, input logic set, input logic rst);
        return rst ? 1'b0 : (set ? 1'b1 : d);
    endfunction

endpackage

// File: rtl/dff_response_checker_if.sv
// Observed DFF signals. The driver/DUT side produces them, the checker only watches.
interface dff_response_checker_if;

    logic dut_d;
    logic dut_set;
    logic dut_reset;
    logic dut_q;

    // No handshake: every signal is valid on every rising clk edge and is
    // consumed unconditionally, so there is no ready/back-pressure path.
    modport master (
        output dut_d,
        output dut_set,
        output dut_reset,
        output dut_q
    );

    modport slave (
        input dut_d,
        input dut_set,
        input dut_reset,
        input dut_q
    );

endinterface

// File: rtl/dff_exp_pipe.sv
// LATENCY-deep shift register of expected values; stage LATENCY-1 is the compare head.
module dff_exp_pipe
    import dff_chk_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic load,
    input  exp_t din,
    output exp_t head
);

    exp_t [LATENCY-1:0] stage_q;
    exp_t [LATENCY-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (clr) begin
            stage_d = '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                stage_d[i] = stage_q[i-1];
            end
            // An unloaded cycle pushes a bubble so nothing stale reaches the head.
            stage_d[0] = load ? din : '0;
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    assign head = stage_q[LATENCY-1];

endmodule

// File: rtl/dff_response_checker.sv
// Response checker for a set/reset D flip-flop: golden model, delayed compare, run statistics.
module dff_response_checker
    import dff_chk_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int LATENCY     = 1,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    dff_response_checker_if.slave mon,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  err_pulse,
    output logic [CNT_W-1:0]      err_count,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      first_err_cycle,
    output logic                  first_err_valid,
    output chk_state_t            state_dbg
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    chk_state_t       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] first_err_cycle_q, first_err_cycle_d;
    logic             first_err_valid_q, first_err_valid_d;

    exp_t sample;
    exp_t head;
    logic enter_run;
    logic leave_run;
    logic stay_run;
    logic mismatch;
    logic pipe_clr;
    logic pipe_load;

    // Every RUN sample has a defined d, so each one is known and valid.
    always_comb begin
        sample.exp   = dff_model(mon.dut_d, mon.dut_set, mon.dut_reset);
        sample.valid = 1'b1;
    end

    assign mismatch = (state_q == RUN) && head.valid && (head.exp != mon.dut_q);

    always_comb begin
        state_d   = state_q;
        enter_run = 1'b0;
        leave_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    enter_run = 1'b1;
                end
            end
            RUN: begin
                if (stop || (STOP_ON_ERR && mismatch)) begin
                    state_d   = DONE;
                    leave_run = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d   = RUN;
                    enter_run = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stay_run  = (state_q == RUN) && !leave_run;
    // Leaving RUN flushes pending expectations so they are never compared.
    assign pipe_clr  = reset || enter_run || leave_run;
    assign pipe_load = stay_run;

    always_comb begin
        err_count_d       = err_count_q;
        cycle_count_d     = cycle_count_q;
        first_err_cycle_d = first_err_cycle_q;
        first_err_valid_d = first_err_valid_q;
        pass_d            = pass_q;
        err_pulse_d       = mismatch;

        if (enter_run) begin
            err_count_d       = '0;
            cycle_count_d     = '0;
            first_err_cycle_d = '0;
            first_err_valid_d = 1'b0;
            pass_d            = 1'b0;
        end else begin
            if (mismatch) begin
                if (err_count_q != CNT_MAX) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
                if (!first_err_valid_q) begin
                    first_err_cycle_d = cycle_count_q;
                    first_err_valid_d = 1'b1;
                end
            end
            // The exit cycle loads no sample, so it is not counted as a run cycle.
            if (stay_run && (cycle_count_q != CNT_MAX)) begin
                cycle_count_d = cycle_count_q + CNT_W'(1);
            end
            if (leave_run) begin
                pass_d = (err_count_d == '0);
            end
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            err_pulse_q       <= 1'b0;
            err_count_q       <= '0;
            cycle_count_q     <= '0;
            first_err_cycle_q <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            err_pulse_q       <= err_pulse_d;
            err_count_q       <= err_count_d;
            cycle_count_q     <= cycle_count_d;
            first_err_cycle_q <= first_err_cycle_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    dff_exp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk  (clk),
        .clr  (pipe_clr),
        .load (pipe_load),
        .din  (sample),
        .head (head)
    );

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_pulse       = err_pulse_q;
    assign err_count       = err_count_q;
    assign cycle_count     = cycle_count_q;
    assign first_err_cycle = first_err_cycle_q;
    assign first_err_valid = first_err_valid_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Directed bench: three checker configurations (L=1, L=1 stop-on-error, L=3) share one stimulus bus.
module tb_dff_response_checker;
    import dff_chk_pkg::*;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start_v, stop_v, q_v;
    logic       drv_d, drv_set, drv_rst;
    logic [2:0] busy_v, done_v, pass_v, pulse_v, fev_v;
    logic [CNT_W-1:0] err_cnt [3];
    logic [CNT_W-1:0] cyc_cnt [3];
    logic [CNT_W-1:0] first_cyc [3];
    chk_state_t st [3];

    dff_response_checker_if bus0 ();
    dff_response_checker_if bus1 ();
    dff_response_checker_if bus2 ();

    assign bus0.dut_d = drv_d;  assign bus0.dut_set = drv_set;  assign bus0.dut_reset = drv_rst;  assign bus0.dut_q = q_v[0];
    assign bus1.dut_d = drv_d;  assign bus1.dut_set = drv_set;  assign bus1.dut_reset = drv_rst;  assign bus1.dut_q = q_v[1];
    assign bus2.dut_d = drv_d;  assign bus2.dut_set = drv_set;  assign bus2.dut_reset = drv_rst;  assign bus2.dut_q = q_v[2];

    dff_response_checker #(.CNT_W(CNT_W), .LATENCY(1), .STOP_ON_ERR(1'b0)) u_l1 (
        .clk(clk), .reset(rst), .start(start_v[0]), .stop(stop_v[0]), .mon(bus0),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_pulse(pulse_v[0]),
        .err_count(err_cnt[0]), .cycle_count(cyc_cnt[0]), .first_err_cycle(first_cyc[0]),
        .first_err_valid(fev_v[0]), .state_dbg(st[0])
    );

    dff_response_checker #(.CNT_W(CNT_W), .LATENCY(1), .STOP_ON_ERR(1'b1)) u_soe (
        .clk(clk), .reset(rst), .start(start_v[1]), .stop(stop_v[1]), .mon(bus1),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_pulse(pulse_v[1]),
        .err_count(err_cnt[1]), .cycle_count(cyc_cnt[1]), .first_err_cycle(first_cyc[1]),
        .first_err_valid(fev_v[1]), .state_dbg(st[1])
    );

    dff_response_checker #(.CNT_W(CNT_W), .LATENCY(3), .STOP_ON_ERR(1'b0)) u_l3 (
        .clk(clk), .reset(rst), .start(start_v[2]), .stop(stop_v[2]), .mon(bus2),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_pulse(pulse_v[2]),
        .err_count(err_cnt[2]), .cycle_count(cyc_cnt[2]), .first_err_cycle(first_cyc[2]),
        .first_err_valid(fev_v[2]), .state_dbg(st[2])
    );

    // {reset, set, d} per run cycle and the hand-computed DFF response to each.
    logic [2:0] vec [7] = '{3'b000, 3'b110, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
    logic       exp_tbl [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int tgt      = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (pulse_v[tgt]) pulses++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic q);
        {drv_rst, drv_set, drv_d} = v;
        q_v[tgt] = q;
        step();
    endtask

    task automatic pulse_start();
        start_v[tgt] = 1'b1;
        step();
        start_v[tgt] = 1'b0;
        pulses = 0;
    endtask

    task automatic pulse_stop(input logic q);
        stop_v[tgt] = 1'b1;
        q_v[tgt]    = q;
        step();
        stop_v[tgt] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_v = '0; stop_v = '0; q_v = '0;
        drv_d = 1'b0; drv_set = 1'b0; drv_rst = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_state", 32'(st[0]), 32'(IDLE));
        chk("rst_busy", 32'(busy_v), 32'd0);
        chk("rst_done", 32'(done_v), 32'd0);
        chk("rst_pass", 32'(pass_v), 32'd0);
        chk("rst_err", 32'(err_cnt[0]), 32'd0);
        chk("rst_cyc", 32'(cyc_cnt[2]), 32'd0);

        // Clean run, L=1: q follows the model one cycle later.
        tgt = 0;
        start_v[0] = 1'b1; stop_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0; stop_v[0] = 1'b0;
        pulses = 0;
        chk("start_stop_busy", 32'(busy_v[0]), 32'd1);
        for (int k = 0; k < 7; k++) drive(vec[k], (k == 0) ? 1'b0 : exp_tbl[k-1]);
        pulse_stop(exp_tbl[6]);
        chk("clean_done", 32'(done_v[0]), 32'd1);
        chk("clean_busy", 32'(busy_v[0]), 32'd0);
        chk("clean_pass", 32'(pass_v[0]), 32'd1);
        chk("clean_err", 32'(err_cnt[0]), 32'd0);
        chk("clean_cyc", 32'(cyc_cnt[0]), 32'd7);
        chk("clean_pulses", 32'(pulses), 32'd0);

        // Same run from DONE, q forced to 1 on cycle 3 only.
        pulse_start();
        chk("rerun_cleared", 32'(pass_v[0]), 32'd0);
        for (int k = 0; k < 7; k++) drive(vec[k], (k == 0) ? 1'b0 : ((k == 3) ? 1'b1 : exp_tbl[k-1]));
        pulse_stop(exp_tbl[6]);
        chk("err1_pulses", 32'(pulses), 32'd1);
        chk("err1_count", 32'(err_cnt[0]), 32'd1);
        chk("err1_first", 32'(first_cyc[0]), 32'd3);
        chk("err1_fev", 32'(fev_v[0]), 32'd1);
        chk("err1_pass", 32'(pass_v[0]), 32'd0);
        chk("err1_done", 32'(done_v[0]), 32'd1);

        // Reset and set both high with d=1: the DFF must give 0, so q=1 is an error.
        pulse_start();
        drive(3'b111, 1'b0);
        drive(3'b000, 1'b1);
        pulse_stop(1'b0);
        chk("prio_err", 32'(err_cnt[0]), 32'd1);
        chk("prio_first", 32'(first_cyc[0]), 32'd1);
        chk("prio_pass", 32'(pass_v[0]), 32'd0);

        // Stop-on-error: mismatches on cycles 2 and 5; only the first counts.
        tgt = 1;
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            drive(vec[k], (k == 0) ? 1'b0 : (exp_tbl[k-1] ^ ((k == 2) || (k == 5))));
            if (k == 2) begin
                chk("soe_done_early", 32'(done_v[1]), 32'd1);
                chk("soe_busy_early", 32'(busy_v[1]), 32'd0);
            end
        end
        pulse_stop(exp_tbl[6]);
        chk("soe_err", 32'(err_cnt[1]), 32'd1);
        chk("soe_first", 32'(first_cyc[1]), 32'd2);
        chk("soe_cyc", 32'(cyc_cnt[1]), 32'd2);
        chk("soe_pulses", 32'(pulses), 32'd1);
        chk("soe_pass", 32'(pass_v[1]), 32'd0);

        // L=3: no compares in cycles 0-2, then stop with two entries still pending.
        tgt = 2;
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            drive(vec[k], (k < 3) ? 1'b1 : exp_tbl[k-3]);
            if (k == 2) chk("l3_fill_quiet", 32'(err_cnt[2]), 32'd0);
        end
        pulse_stop(exp_tbl[4]);
        drive(3'b000, ~exp_tbl[5]);
        drive(3'b000, ~exp_tbl[6]);
        chk("l3_err", 32'(err_cnt[2]), 32'd0);
        chk("l3_pulses", 32'(pulses), 32'd0);
        chk("l3_pass", 32'(pass_v[2]), 32'd1);
        chk("l3_cyc", 32'(cyc_cnt[2]), 32'd7);
        chk("l3_done", 32'(done_v[2]), 32'd1);

        // Checker reset mid-run after two errors, then a clean run.
        tgt = 0;
        pulse_start();
        drive(vec[0], 1'b0);
        drive(vec[1], ~exp_tbl[0]);
        drive(vec[2], ~exp_tbl[1]);
        chk("mid_err2", 32'(err_cnt[0]), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_state", 32'(st[0]), 32'(IDLE));
        chk("mid_rst_err", 32'(err_cnt[0]), 32'd0);
        chk("mid_rst_fev", 32'(fev_v[0]), 32'd0);
        chk("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        chk("mid_rst_cyc", 32'(cyc_cnt[0]), 32'd0);
        pulse_start();
        for (int k = 0; k < 7; k++) drive(vec[k], (k == 0) ? 1'b0 : exp_tbl[k-1]);
        pulse_stop(exp_tbl[6]);
        chk("after_rst_pass", 32'(pass_v[0]), 32'd1);
        chk("after_rst_err", 32'(err_cnt[0]), 32'd0);
        chk("after_rst_cyc", 32'(cyc_cnt[0]), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_response_checker.md
Name: dff_response_checker

Overview:
- Synthesizable response checker for the D flip-flop with set/reset.
- Observes the same signals the stimulus driver applies (d, set, reset) plus the DUT output q.
- Runs its own golden model, compares it against q at a fixed latency, and reports error count, first-error cycle and a pass/fail verdict.
- Sits beside the DUT in the DFF bench. It is the consuming/checking end of the DFF interface, where the driver is the producing end.

Parameters:
- CNT_W, 16: width of all counters (cycle, error, first-error index).
- LATENCY, 1: clock cycles from sampled inputs to the DUT q update. Legal range 1..4.
- STOP_ON_ERR, 0: 1 = enter DONE on the first mismatch.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high reset of the checker itself.
- start, input, 1: one-cycle pulse; begins a check run.
- stop, input, 1: one-cycle pulse; ends a run.
- dut_d, input, 1: observed DUT data input.
- dut_set, input, 1: observed DUT set.
- dut_reset, input, 1: observed DUT reset (the DUT's, not the checker's).
- dut_q, input, 1: observed DUT output.
- busy, output, 1: high in RUN.
- done, output, 1: high in DONE.
- pass, output, 1: valid in DONE; 1 iff err_count == 0.
- err_pulse, output, 1: one-cycle pulse on each mismatch.
- err_count, output, CNT_W: mismatches in the current/last run; saturates at all-ones.
- cycle_count, output, CNT_W: RUN cycles elapsed; saturates at all-ones.
- first_err_cycle, output, CNT_W: cycle_count value at the first mismatch.
- first_err_valid, output, 1: first_err_cycle holds a value.

Behaviour:
- Checker reset (reset = 1 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0 and all counters are 0.
  - The expectation pipe is cleared, including all valid bits.
  - Reset takes priority over start and stop, including mid-run.
- Golden model, evaluated on signals sampled each RUN cycle:
  - exp = dut_reset ? 0 : (dut_set ? 1 : dut_d).
  - Reset beats set when both are 1.
  - Each sample carries a known bit. known = 1 once dut_reset or dut_set has been sampled at 1 during the run, or after any sample (d is always defined). In practice every RUN sample is known; the bit exists so the pipe can be flushed.
- Expectation pipe:
  - LATENCY stages of {exp, valid}.
  - Stage 0 loads the current sample with valid = 1 while in RUN.
  - Stages shift every cycle.
- Compare:
  - When the head stage is valid, compare its exp against dut_q in that same cycle.
  - The first LATENCY cycles of a run compare nothing because the pipe is still filling.
  - A mismatch drives err_pulse = 1 for that cycle and increments err_count (saturating).
  - If first_err_valid = 0, the mismatch also latches first_err_cycle = cycle_count and sets first_err_valid = 1.
- State machine:
  - IDLE → RUN on start. Entering RUN clears counters, first_err_*, the pipe and pass.
  - In IDLE, stop is ignored.
  - RUN: cycle_count increments every cycle. start is ignored.
  - RUN → DONE on stop, or on a mismatch when STOP_ON_ERR = 1.
  - The stop cycle's sample is not loaded into the pipe. Pending pipe entries are discarded without comparison.
  - The mismatch that triggers STOP_ON_ERR is counted and latched first.
  - RUN → DONE transition: pass = (err_count_next == 0).
  - DONE: outputs hold. start → RUN with a fresh clear. stop is ignored.
- Simultaneous events:
  - start and stop in the same IDLE cycle: go to RUN.
  - stop and mismatch in the same cycle: the mismatch is counted, then DONE.
- Outputs are registered. done, busy and pass change one cycle after the triggering edge input is sampled.

Decomposition:
- Package dff_chk_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_t.
  - typedef struct packed {logic exp; logic valid;} exp_t.
  - Constant MAX_LATENCY = 4.
- One sub-module, dff_exp_pipe: parameterized LATENCY-deep shift register of exp_t, with synchronous clear and load-enable.
- The top level holds the FSM, the golden model, the compare logic and the counters.

Test Plan:
- Directed stimulus: reset, pulse start, then drive {reset,set,d} = 000, 110, 000, 001, 000, 001, 000 over 7 cycles with a correct DUT (q follows the model at LATENCY = 1), then stop.
  → done = 1, pass = 1, err_count = 0, cycle_count = 7.
- Same sequence with dut_q forced to 1 on cycle 3 only.
  → err_pulse high exactly once, err_count = 1, first_err_cycle = 3, first_err_valid = 1, pass = 0.
- Priority check: reset = set = 1 with d = 1, and the DUT outputs q = 1.
  → mismatch flagged; confirms reset beats set.
- STOP_ON_ERR = 1, with a mismatch on cycle 2 and another on cycle 5.
  → DONE after cycle 2, err_count = 1, and the cycle-5 error is not counted.
- LATENCY = 3, correct DUT delayed 3 cycles.
  → no compares in cycles 0–2, pass = 1. Then stop mid-stream: pending entries are discarded and err_count stays 0.
- Checker reset asserted mid-RUN after 2 errors.
  → IDLE, err_count = 0, first_err_valid = 0, busy = 0. A following start gives a clean run.
